thermo_led_driver: RTL

- Downstream consumer of the 15-bit thermometer count produced by the counter/thermometer-coder stage; drives a 15-LED bar.
- Registers the incoming code, checks it is a legal thermometer code, recovers the binary level and rejects bubbled codes by holding the last valid display.
- Dims the bar with an internal PWM and keeps a saturating count of bubble events for debug.

---
 rtl/thermo_led_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/thermo_led_driver.sv
// thermo_led_driver
//
// Takes the 15-bit thermometer code from the upstream counter/coder stage and
// drives a 15-LED bar. The code is registered first and then checked. A legal
// code is 0, all ones, or a contiguous run of ones starting at bit 0.
// Legal codes are shown on the bar, and their binary level is recovered.
// A bubbled code (a 0 below a 1) moves the block into HOLD. In HOLD the last
// good display stays frozen until GOOD_RUN consecutive legal samples arrive.
// The bar is dimmed by a free-running PWM. A saturating counter records
// RUN->HOLD transitions for debug.
//
// Optional feature (macro BLINK_ON_ERROR_EN): the held bar flashes while in
// HOLD. A blink register toggles on every en_clk tick. Without the macro
// the held bar stays steady, and bubble_err is the only error indication.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   thermo_in   [WIDTH]    thermometer code from the upstream stage
//   en_clk      one-clk slow tick (blink timebase, used only with the macro)
//   brightness  [LVL_BITS] PWM duty, 0 = off, 15 = fully on
//   err_clr     synchronous clear of err_count (wins over an increment)
//   led         [WIDTH]    registered, PWM-gated LED drive
//   level       [LVL_BITS] binary level of the displayed code
//   bubble_err  high while in HOLD
//   err_count   [ERR_BITS] saturating count of RUN->HOLD transitions
module thermo_led_driver #(
    parameter int WIDTH    = 15,
    parameter int LVL_BITS = 4,
    parameter int GOOD_RUN = 2,
    parameter int ERR_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    thermo_in,
    input  logic                en_clk,
    input  logic [LVL_BITS-1:0] brightness,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    led,
    output logic [LVL_BITS-1:0] level,
    output logic                bubble_err,
    output logic [ERR_BITS-1:0] err_count
);

    localparam int GC_W = $clog2(GOOD_RUN + 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t              state;
    logic [WIDTH-1:0]    in_q;
    logic [WIDTH-1:0]    disp_code;
    logic [LVL_BITS-1:0] pwm_cnt;
    logic [GC_W-1:0]     good_cnt;

    // A legal thermometer code plus one is a power of two (or 2^WIDTH).
    // So ANDing the code with its successor yields zero only for legal codes.
    // The successor is formed one bit wider so that all ones wraps cleanly.
    logic [WIDTH:0] in_inc;
    logic           in_valid;
    assign in_inc   = {1'b0, in_q} + (WIDTH+1)'(1);
    assign in_valid = ((in_inc & {1'b0, in_q}) == '0);

    // Popcount by prefix sums; for a legal code this equals the level.
    logic [LVL_BITS-1:0] pc [WIDTH+1];
    assign pc[0] = '0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_popcount
            assign pc[gi+1] = pc[gi] + LVL_BITS'(in_q[gi]);
        end
    endgenerate

    // pwm_cnt never exceeds WIDTH-1.
    // This makes full brightness constantly on and zero brightness constantly off.
    logic pwm_on;
    assign pwm_on = (pwm_cnt < brightness);

    logic led_gate;
`ifdef BLINK_ON_ERROR_EN
    logic blink;
    assign led_gate = pwm_on & blink;
`else
    logic unused_en_clk;
    assign unused_en_clk = en_clk;
    assign led_gate      = pwm_on;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            in_q       <= '0;
            disp_code  <= '0;
            level      <= '0;
            led        <= '0;
            bubble_err <= 1'b0;
            err_count  <= '0;
            pwm_cnt    <= '0;
            good_cnt   <= '0;
`ifdef BLINK_ON_ERROR_EN
            blink      <= 1'b0;
`endif
        end else begin
            in_q    <= thermo_in;
            pwm_cnt <= (pwm_cnt == LVL_BITS'(WIDTH-1)) ? '0 : pwm_cnt + LVL_BITS'(1);
            led     <= disp_code & {WIDTH{led_gate}};

            case (state)
                RUN: begin
                    if (in_valid) begin
                        disp_code <= in_q;
                        level     <= pc[WIDTH];
                    end else begin
                        state      <= HOLD;
                        bubble_err <= 1'b1;
                        good_cnt   <= '0;
                        if (err_count != '1)
                            err_count <= err_count + ERR_BITS'(1);
                    end
                end
                HOLD: begin
                    if (in_valid) begin
                        if (good_cnt == GC_W'(GOOD_RUN-1)) begin
                            // The sample that completes the good run is displayed.
                            disp_code  <= in_q;
                            level      <= pc[WIDTH];
                            state      <= RUN;
                            bubble_err <= 1'b0;
                            good_cnt   <= '0;
                        end else begin
                            good_cnt <= good_cnt + GC_W'(1);
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end
                default: state <= RUN;
            endcase

            // Placed after the FSM so a clear overrides a same-cycle increment.
            if (err_clr)
                err_count <= '0;

`ifdef BLINK_ON_ERROR_EN
            if (state == HOLD) begin
                if (en_clk)
                    blink <= ~blink;
            end else begin
                blink <= 1'b1;
            end
`endif
        end
    end

endmodule
